// File: rtl/color_code_seq.sv
// Sequential binary-to-colour-code driver: a shift-and-add-3 engine converts one
// bit per clock into BCD, and each digit is mapped to a 12-bit RGB palette entry.
module color_code_seq #(
    parameter int WIDTH   = 6,
    parameter int DIGITS  = 2,
    parameter int BLINK_W = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIDTH-1:0]       num,
    input  logic                   blink_en,
    output logic                   busy,
    output logic                   done,
    output logic                   ovf,
    output logic [12*DIGITS-1:0]   code
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_W = 4 * DIGITS;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam logic [63:0] OVF_LIMIT = pow10(DIGITS);

    function automatic logic [11:0] palette(input logic [3:0] d);
        case (d)
            4'd0:    palette = 12'h000;
            4'd1:    palette = 12'hF00;
            4'd2:    palette = 12'hF80;
            4'd3:    palette = 12'hFF0;
            4'd4:    palette = 12'h0F0;
            4'd5:    palette = 12'h0FF;
            4'd6:    palette = 12'h08F;
            4'd7:    palette = 12'h00F;
            4'd8:    palette = 12'hF0F;
            4'd9:    palette = 12'hFFF;
            default: palette = 12'h000;
        endcase
    endfunction

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [WIDTH-1:0]      r_bin;
    logic [BCD_W-1:0]      r_bcd;
    logic                  r_ovf_pend;
    logic                  r_ovf;
    logic [12*DIGITS-1:0]  r_code;
    logic [BLINK_W-1:0]    r_blink;

    logic [BCD_W-1:0]      w_bcd_adj;
    logic [BCD_W-1:0]      w_bcd_next;
    logic [WIDTH-1:0]      w_bin_next;
    logic [12*DIGITS-1:0]  w_code_next;
    logic                  w_num_ovf;
    logic                  w_blank;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Bits shifted out of the top digit are dropped; lower digits stay exact mod 10.
    assign w_bcd_next = {w_bcd_adj[BCD_W-2:0], r_bin[WIDTH-1]};
    assign w_bin_next = r_bin << 1;

    always_comb begin
        w_code_next = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_code_next[12*i +: 12] = palette(w_bcd_next[4*i +: 4]);
        end
    end

    assign w_num_ovf = ({{(64-WIDTH){1'b0}}, num} >= OVF_LIMIT);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_ovf_pend <= 1'b0;
            r_ovf      <= 1'b0;
            r_code     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bin      <= num;
                        r_bcd      <= '0;
                        r_cnt      <= CNT_W'(WIDTH);
                        r_ovf_pend <= w_num_ovf;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_bin <= w_bin_next;
                    r_bcd <= w_bcd_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_code  <= w_code_next;
                        r_ovf   <= r_ovf_pend;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink <= '0;
        end else begin
            r_blink <= r_blink + 1'b1;
        end
    end

    assign w_blank = blink_en & r_ovf & r_blink[BLINK_W-1];

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign ovf  = r_ovf;
    assign code = w_blank ? '0 : r_code;

endmodule
